// File: rtl/i2s_pkg.sv
// Shared types and default sizes for the I2S deserializer.
package i2s_pkg;

  localparam int SAMPLE_W_DEF    = 14;
  localparam int MAX_BITS_DEF    = 32;
  localparam int LOSS_CYCLES_DEF = 1024;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_RUN  = 2'd2
  } align_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser plus history flop; gives the synced level and a
// one-cycle rising-edge pulse, all with the same delay.
module i2s_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic stage1;
  logic stage2;
  logic hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1 <= 1'b0;
      stage2 <= 1'b0;
      hist   <= 1'b0;
    end else begin
      stage1 <= async_in;
      stage2 <= stage1;
      hist   <= stage2;
    end
  end

  assign level = stage2;
  assign rise  = stage2 & ~hist;

endmodule

// File: rtl/i2s_deserializer.sv
// I2S receiver: oversamples BCK/WS/DATA, deserialises MSB-first words into
// left-aligned stereo pairs with a one-cycle valid strobe.
// Optional stream-loss watchdog enabled with `define I2S_LOSS_DETECT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no BCK edge seen since reset/loss; le_prev not yet meaningful
// ST_SEEK | waiting for the first WS transition; words are discarded
// ST_RUN  | aligned; every WS transition closes a word for output
module i2s_deserializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int MAX_BITS    = MAX_BITS_DEF,
  parameter int LOSS_CYCLES = LOSS_CYCLES_DEF
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_bck,
  input  logic                in_le,
  input  logic                in_data,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                out_valid,
  output logic                out_lost
);

  localparam int CNT_W = $clog2(MAX_BITS + 1);

  logic bck_rise;
  logic le_s;
  logic data_s;
  logic unused_bck_level;
  logic unused_le_rise;
  logic unused_data_rise;

  i2s_sync_edge u_sync_bck (
    .clk      (in_clk),
    .rst      (in_rst),
    .async_in (in_bck),
    .level    (unused_bck_level),
    .rise     (bck_rise)
  );

  i2s_sync_edge u_sync_le (
    .clk      (in_clk),
    .rst      (in_rst),
    .async_in (in_le),
    .level    (le_s),
    .rise     (unused_le_rise)
  );

  i2s_sync_edge u_sync_data (
    .clk      (in_clk),
    .rst      (in_rst),
    .async_in (in_data),
    .level    (data_s),
    .rise     (unused_data_rise)
  );

  align_state_t        state;
  align_state_t        state_next;
  logic                le_prev;
  logic                ws_change;
  logic                close_en;
  logic                drop_align;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] word_reg;
  logic [SAMPLE_W-1:0] word_cur;
  logic [SAMPLE_W-1:0] close_word;
  logic [SAMPLE_W-1:0] left_hold;
  logic                close_vld;
  channel_t            close_ch;
  logic                left_ok;

  assign ws_change = (le_s != le_prev);

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bck_rise) state_next = ST_SEEK;
      ST_SEEK: if (bck_rise && ws_change) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
    if (drop_align) state_next = ST_IDLE;
  end

  always_comb begin
    close_en = (state == ST_RUN) && bck_rise && ws_change;
  end

  // Word including the bit on the current edge; a fresh word starts from zero
  // so short words come out zero-padded.
  always_comb begin
    word_cur = (bit_cnt == '0) ? '0 : word_reg;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (bit_cnt == CNT_W'(i)) word_cur[SAMPLE_W-1-i] = data_s;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      le_prev    <= 1'b0;
      bit_cnt    <= '0;
      word_reg   <= '0;
      close_vld  <= 1'b0;
      close_ch   <= CH_LEFT;
      close_word <= '0;
      left_hold  <= '0;
      left_ok    <= 1'b0;
      out_left   <= '0;
      out_right  <= '0;
      out_valid  <= 1'b0;
    end else begin
      close_vld <= close_en;
      out_valid <= 1'b0;
      if (bck_rise) begin
        le_prev <= le_s;
        if (ws_change) begin
          bit_cnt    <= '0;
          close_ch   <= channel_t'(le_prev);
          close_word <= word_cur;
        end else begin
          word_reg <= word_cur;
          if (bit_cnt != CNT_W'(MAX_BITS)) bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
      if (close_vld) begin
        if (close_ch == CH_LEFT) begin
          left_hold <= close_word;
          left_ok   <= 1'b1;
        end else if (left_ok) begin
          out_left  <= left_hold;
          out_right <= close_word;
          out_valid <= 1'b1;
          left_ok   <= 1'b0;
        end
      end
      // Loss mutes the outputs and discards any half-built pair.
      if (drop_align) begin
        out_left  <= '0;
        out_right <= '0;
        out_valid <= 1'b0;
        left_ok   <= 1'b0;
        close_vld <= 1'b0;
      end
    end
  end

`ifdef I2S_LOSS_DETECT_EN
  localparam int WD_W = $clog2(LOSS_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      wd_cnt   <= '0;
      out_lost <= 1'b0;
    end else if (bck_rise) begin
      wd_cnt   <= '0;
      out_lost <= 1'b0;
    end else if (wd_cnt != WD_W'(LOSS_CYCLES)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt == WD_W'(LOSS_CYCLES - 1)) out_lost <= 1'b1;
    end
  end

  assign drop_align = out_lost;
`else
  assign out_lost   = 1'b0;
  assign drop_align = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_deserializer.sv
// Self-checking bench for i2s_deserializer: directed frames plus randomised
// word lengths/data checked against a word-level reference model.
module tb_i2s_deserializer;

  localparam int SW = 14;

  logic          in_clk = 1'b0;
  logic          in_rst;
  logic          in_bck;
  logic          in_le;
  logic          in_data;
  logic [SW-1:0] out_left;
  logic [SW-1:0] out_right;
  logic          out_valid;
  logic          out_lost;

  int checks = 0;
  int errors = 0;

  logic [1:0]      stream[$];
  logic [1:0]      seen[$];
  logic [2*SW-1:0] mon_q[$];
  logic [2*SW-1:0] exp_q[$];

  always #10 in_clk = ~in_clk;

  i2s_deserializer dut (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_bck    (in_bck),
    .in_le     (in_le),
    .in_data   (in_data),
    .out_left  (out_left),
    .out_right (out_right),
    .out_valid (out_valid),
    .out_lost  (out_lost)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge in_clk);
      #1;
      if (out_valid === 1'b1) mon_q.push_back({out_left, out_right});
    end
  end

  // One word of n bits, MSB first; the LSB carries the next channel's WS.
  task automatic add_word(input logic ch, input int n, input logic [63:0] val);
    for (int i = n - 1; i >= 0; i--) stream.push_back({(i == 0) ? ~ch : ch, val[i]});
  endtask

  // Reference: split the observed bit stream into words at WS changes, drop
  // everything up to the first change, left-align, pair left with right.
  task automatic build_model();
    logic          cur[$];
    logic          have_prev;
    logic          aligned;
    logic          lok;
    logic          prev_le;
    logic [SW-1:0] lh;
    logic [SW-1:0] w;
    have_prev = 1'b0;
    aligned   = 1'b0;
    lok       = 1'b0;
    prev_le   = 1'b0;
    lh        = '0;
    exp_q.delete();
    foreach (seen[k]) begin
      cur.push_back(seen[k][0]);
      if (have_prev && seen[k][1] != prev_le) begin
        if (aligned) begin
          w = '0;
          for (int j = 0; j < SW; j++) w = {w[SW-2:0], (j < cur.size()) ? cur[j] : 1'b0};
          if (prev_le == 1'b0) begin
            lh  = w;
            lok = 1'b1;
          end else if (lok) begin
            exp_q.push_back({lh, w});
            lok = 1'b0;
          end
        end
        aligned = 1'b1;
        cur.delete();
      end
      prev_le   = seen[k][1];
      have_prev = 1'b1;
    end
  endtask

  // BCK = in_clk/8; optionally measures strobe latency on this bit's rising edge.
  task automatic drive_bit(input logic [1:0] b, input bit meas);
    @(negedge in_clk);
    in_bck  = 1'b0;
    in_le   = b[1];
    in_data = b[0];
    repeat (4) @(negedge in_clk);
    in_bck = 1'b1;
    if (meas) begin
      int lat;
      int n;
      lat = -1;
      n   = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge in_clk);
        #1;
        if (out_valid === 1'b1) begin
          n++;
          if (lat < 0) lat = k;
        end
      end
      check_val("latency", 32'(lat), 32'd3);
      check_val("valid_width", 32'(n), 32'd1);
    end else begin
      repeat (3) @(negedge in_clk);
    end
  endtask

  task automatic run_stream(input int rst_until, input int meas_idx);
    foreach (stream[i]) begin
      if (i == 0 && rst_until > 0) in_rst = 1'b1;
      if (rst_until > 0 && i == rst_until) begin
        @(negedge in_clk);
        in_bck = 1'b0;
        repeat (2) @(negedge in_clk);
        check_val("rst_left", 32'(out_left), 32'd0);
        check_val("rst_right", 32'(out_right), 32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        in_rst = 1'b0;
        seen.delete();
        mon_q.delete();
      end
      drive_bit(stream[i], i == meas_idx);
      if (i >= rst_until) seen.push_back(stream[i]);
    end
    stream.delete();
  endtask

  task automatic finish_test(input string tag);
    @(negedge in_clk);
    in_bck = 1'b0;
    repeat (20) @(negedge in_clk);
    build_model();
    check_val({tag, "_pairs"}, 32'(mon_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < mon_q.size()) check_val($sformatf("%s_pair%0d", tag, i), 32'(mon_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic do_reset();
    in_rst  = 1'b1;
    in_bck  = 1'b0;
    in_le   = 1'b0;
    in_data = 1'b0;
    repeat (4) @(negedge in_clk);
    check_val("reset_left", 32'(out_left), 32'd0);
    check_val("reset_right", 32'(out_right), 32'd0);
    check_val("reset_valid", 32'(out_valid), 32'd0);
    check_val("reset_lost", 32'(out_lost), 32'd0);
    in_rst = 1'b0;
    seen.delete();
    mon_q.delete();
  endtask

  task automatic add_random_frames(input logic first_ch, input int n_words, input int min_len, input int max_len);
    logic ch;
    ch = first_ch;
    for (int w = 0; w < n_words; w++) begin
      add_word(ch, $urandom_range(max_len, min_len), {$urandom, $urandom});
      ch = ~ch;
    end
  endtask

  initial begin : main
    logic p;
    in_rst  = 1'b1;
    in_bck  = 1'b0;
    in_le   = 1'b0;
    in_data = 1'b0;

    // 32-bit slots, fixed values
    do_reset();
    add_word(1'b1, 5, 64'h0);
    for (int f = 0; f < 3; f++) begin
      add_word(1'b0, 32, 64'h7FFC0000);
      add_word(1'b1, 32, 64'h80040000);
    end
    run_stream(0, -1);
    finish_test("t1");
    check_val("t1_count", 32'(mon_q.size()), 32'd3);
    if (mon_q.size() > 0) begin
      check_val("t1_left", 32'(mon_q[0][2*SW-1:SW]), 32'h1FFF);
      check_val("t1_right", 32'(mon_q[0][SW-1:0]), 32'h2001);
    end

    // 16-bit slots followed by 12-bit slots
    do_reset();
    add_word(1'b1, 4, 64'h5);
    add_word(1'b0, 16, 64'h1234);
    add_word(1'b1, 16, 64'hFEDC);
    add_word(1'b0, 12, 64'hABC);
    add_word(1'b1, 12, 64'h5A5);
    run_stream(0, -1);
    finish_test("t2");
    check_val("t2_count", 32'(mon_q.size()), 32'd2);
    if (mon_q.size() > 1) begin
      check_val("t2_left16", 32'(mon_q[0][2*SW-1:SW]), 32'h048D);
      check_val("t2_right16", 32'(mon_q[0][SW-1:0]), 32'h3FB7);
      check_val("t2_left12", 32'(mon_q[1][2*SW-1:SW]), 32'h2AF0);
      check_val("t2_right12", 32'(mon_q[1][SW-1:0]), 32'h1694);
    end

    // Reset released in the middle of a right word, with a left word held
    do_reset();
    add_word(1'b1, 3, 64'h2);
    add_random_frames(1'b0, 3, 24, 24);
    run_stream(0, -1);
    finish_test("t3a");
    add_word(1'b1, 20, {$urandom, $urandom});
    add_random_frames(1'b0, 4, 24, 24);
    run_stream(8, -1);
    finish_test("t3b");
    check_val("t3_count", 32'(mon_q.size()), 32'd2);

    // Random lengths including 1-bit WS glitches and orphan right words
    for (int r = 0; r < 4; r++) begin
      do_reset();
      p = 1'($urandom_range(1, 0));
      add_word(p, $urandom_range(6, 2), {$urandom, $urandom});
      add_random_frames(~p, 10, 1, 40);
      run_stream(0, -1);
      finish_test($sformatf("t4r%0d", r));
    end

    // Latency from the closing BCK edge to out_valid
    do_reset();
    add_word(1'b1, 3, 64'h1);
    add_random_frames(1'b0, 2, 20, 20);
    run_stream(0, stream.size() - 1);
    finish_test("t5");

`ifdef I2S_LOSS_DETECT_EN
    do_reset();
    add_word(1'b1, 3, 64'h3);
    add_random_frames(1'b0, 2, 16, 16);
    run_stream(0, -1);
    @(negedge in_clk);
    in_bck = 1'b0;
    repeat (1000) @(negedge in_clk);
    check_val("lost_early", 32'(out_lost), 32'd0);
    check_val("lost_pairs", 32'(mon_q.size()), 32'd1);
    repeat (60) @(negedge in_clk);
    check_val("lost_set", 32'(out_lost), 32'd1);
    check_val("lost_mute_l", 32'(out_left), 32'd0);
    check_val("lost_mute_r", 32'(out_right), 32'd0);
    mon_q.delete();
    drive_bit(2'b10, 1'b0);
    repeat (3) @(negedge in_clk);
    check_val("lost_clear", 32'(out_lost), 32'd0);
    check_val("lost_no_valid", 32'(mon_q.size()), 32'd0);
    seen.delete();
    add_word(1'b1, 3, 64'h6);
    add_random_frames(1'b0, 4, 18, 18);
    run_stream(0, -1);
    finish_test("t6");
    check_val("t6_count", 32'(mon_q.size()), 32'd2);
`else
    check_val("lost_tied", 32'(out_lost), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
